// File: rtl/pim_dbg_trace.sv
// -----------------------------------------------------------------------------
// pim_dbg_trace
// Trace capture buffer for the PIM debug packer. Qualified samples (address
// handshakes, read-FIFO pops, write-FIFO pushes) are written into a circular
// 1W/1R RAM. An address-match trigger, after a programmable number of
// post-trigger samples, freezes the buffer. A host-side read port dumps it.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   PIM_dbg[127:0]    packed debug vector (Addr, AddrAck, RNW, Pop, Push, data)
//   Arm               pulse: clear pointers and (re)start capture
//   Trig_Addr/Mask    trigger address and per-bit compare enable
//   Rd_En/Rd_Addr     buffer read request
//   Rd_Data/Rd_Valid  buffer read response, one cycle after Rd_En
//   State, Done       capture state (0 IDLE, 1 PRE, 2 POST, 3 DONE)
//   Wr_Ptr, Trig_Ptr  next write address, address of the trigger sample
//   Wrapped           buffer has wrapped since Arm (oldest entry is Wr_Ptr)
// -----------------------------------------------------------------------------
module pim_dbg_trace #(
    parameter int C_DEPTH_LOG2 = 6,
    parameter int C_POST_TRIG  = 48
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [127:0]            PIM_dbg,
    input  logic                    Arm,
    input  logic [31:0]             Trig_Addr,
    input  logic [31:0]             Trig_Mask,
    input  logic                    Rd_En,
    input  logic [C_DEPTH_LOG2-1:0] Rd_Addr,
    output logic [127:0]            Rd_Data,
    output logic                    Rd_Valid,
    output logic [1:0]              State,
    output logic                    Done,
    output logic [C_DEPTH_LOG2-1:0] Wr_Ptr,
    output logic [C_DEPTH_LOG2-1:0] Trig_Ptr,
    output logic                    Wrapped
);

    localparam int DEPTH = 2 ** C_DEPTH_LOG2;
    localparam logic [C_DEPTH_LOG2-1:0] PTR_ZERO  = {C_DEPTH_LOG2{1'b0}};
    localparam logic [C_DEPTH_LOG2-1:0] PTR_ONE   = {{(C_DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [C_DEPTH_LOG2-1:0] PTR_MAX   = {C_DEPTH_LOG2{1'b1}};
    localparam logic [C_DEPTH_LOG2-1:0] POST_INIT = C_DEPTH_LOG2'(C_POST_TRIG);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_POST = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    state_e                  state_q,    state_d;
    logic [C_DEPTH_LOG2-1:0] wr_ptr_q,   wr_ptr_d;
    logic [C_DEPTH_LOG2-1:0] trig_ptr_q, trig_ptr_d;
    logic [C_DEPTH_LOG2-1:0] post_cnt_q, post_cnt_d;
    logic                    wrapped_q,  wrapped_d;
    logic                    done_q,     done_d;
    logic [127:0]            rd_data_q;
    logic                    rd_valid_q;
    logic                    wr_en_s;
    logic                    qual_s;
    logic                    hit_s;

    logic [127:0] mem [DEPTH];

    // Sample qualification and masked address-match trigger
    always_comb begin
        qual_s = PIM_dbg[32] | PIM_dbg[39] | PIM_dbg[61];
        hit_s  = qual_s & PIM_dbg[32] &
                 (((PIM_dbg[31:0] ^ Trig_Addr) & Trig_Mask) == 32'd0);
    end

    // Capture FSM next-state, pointer and write-enable logic
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        trig_ptr_d = trig_ptr_q;
        post_cnt_d = post_cnt_q;
        wrapped_d  = wrapped_q;
        wr_en_s    = 1'b0;
        if (Arm) begin
            // Arm wins over everything, including a hit in the same cycle
            state_d    = ST_PRE;
            wr_ptr_d   = PTR_ZERO;
            trig_ptr_d = PTR_ZERO;
            post_cnt_d = PTR_ZERO;
            wrapped_d  = 1'b0;
        end else begin
            case (state_q)
                ST_PRE, ST_POST: begin
                    if (qual_s) begin
                        wr_en_s  = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                        if (wr_ptr_q == PTR_MAX) begin
                            wrapped_d = 1'b1;
                        end else begin
                            wrapped_d = wrapped_q;
                        end
                        if (state_q == ST_PRE) begin
                            if (hit_s) begin
                                trig_ptr_d = wr_ptr_q;
                                post_cnt_d = POST_INIT;
                                state_d    = (POST_INIT == PTR_ZERO) ? ST_DONE : ST_POST;
                            end else begin
                                state_d = ST_PRE;
                            end
                        end else begin
                            // The write that brings the count to zero is the last one
                            post_cnt_d = post_cnt_q - PTR_ONE;
                            if (post_cnt_q == PTR_ONE) begin
                                state_d = ST_DONE;
                            end else begin
                                state_d = ST_POST;
                            end
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_IDLE: state_d = ST_IDLE;
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
        done_d = (state_d == ST_DONE);
    end

    // Capture state and pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= PTR_ZERO;
            trig_ptr_q <= PTR_ZERO;
            post_cnt_q <= PTR_ZERO;
            wrapped_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            trig_ptr_q <= trig_ptr_d;
            post_cnt_q <= post_cnt_d;
            wrapped_q  <= wrapped_d;
            done_q     <= done_d;
        end
    end

    // Trace RAM write port (contents deliberately not reset)
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem[wr_ptr_q] <= PIM_dbg;
        end
    end

    // Trace RAM read port; read-first against a same-cycle write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= 128'd0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= Rd_En;
            if (Rd_En) begin
                rd_data_q <= mem[Rd_Addr];
            end
        end
    end

    assign Rd_Data  = rd_data_q;
    assign Rd_Valid = rd_valid_q;
    assign State    = state_q;
    assign Done     = done_q;
    assign Wr_Ptr   = wr_ptr_q;
    assign Trig_Ptr = trig_ptr_q;
    assign Wrapped  = wrapped_q;

endmodule

// File: tb/tb_pim_dbg_trace.sv
// -----------------------------------------------------------------------------
// tb_pim_dbg_trace
// Directed self-checking bench for pim_dbg_trace with a 16-entry buffer and a
// post-trigger count of 4. One task per scenario, each with inline checks.
// -----------------------------------------------------------------------------
module tb_pim_dbg_trace;

    logic         clk;
    logic         rst_n;
    logic [127:0] PIM_dbg;
    logic         Arm;
    logic [31:0]  Trig_Addr;
    logic [31:0]  Trig_Mask;
    logic         Rd_En;
    logic [3:0]   Rd_Addr;
    logic [127:0] Rd_Data;
    logic         Rd_Valid;
    logic [1:0]   State;
    logic         Done;
    logic [3:0]   Wr_Ptr;
    logic [3:0]   Trig_Ptr;
    logic         Wrapped;

    int tests = 0;
    int fails = 0;

    pim_dbg_trace #(.C_DEPTH_LOG2(4), .C_POST_TRIG(4)) dut (
        .clk(clk), .rst_n(rst_n), .PIM_dbg(PIM_dbg), .Arm(Arm),
        .Trig_Addr(Trig_Addr), .Trig_Mask(Trig_Mask),
        .Rd_En(Rd_En), .Rd_Addr(Rd_Addr), .Rd_Data(Rd_Data), .Rd_Valid(Rd_Valid),
        .State(State), .Done(Done), .Wr_Ptr(Wr_Ptr), .Trig_Ptr(Trig_Ptr),
        .Wrapped(Wrapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] mk(input logic ack, input logic pop, input logic push,
                                        input logic [31:0] addr, input logic [31:0] rdata,
                                        input logic [31:0] wdata);
        logic [127:0] v;
        v          = 128'd0;
        v[31:0]    = addr;
        v[32]      = ack;
        v[39]      = pop;
        v[61]      = push;
        v[95:64]   = rdata;
        v[127:96]  = wdata;
        return v;
    endfunction

    // One clock with the given Arm/PIM_dbg; outputs are sampled 1 time unit later
    task automatic tick(input logic arm, input logic [127:0] dbg);
        Arm     = arm;
        PIM_dbg = dbg;
        @(posedge clk);
        #1;
        Arm     = 1'b0;
        PIM_dbg = 128'd0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (State !== 2'd0) begin fails++; $display("FAIL reset_state got=%0d exp=0", State); end
        tests++; if (Done !== 1'b0) begin fails++; $display("FAIL reset_done got=%0b exp=0", Done); end
        tests++; if (Rd_Data !== 128'd0) begin fails++; $display("FAIL reset_rd_data got=%h exp=0", Rd_Data); end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, mk(1'b1, 1'b1, 1'b1, 32'h1000, 32'h0, 32'h0));
            tests++;
            if (State !== 2'd0 || Wr_Ptr !== 4'd0 || Rd_Valid !== 1'b0) begin
                fails++;
                $display("FAIL idle_no_arm cyc=%0d got state=%0d wr=%0d rv=%0b exp 0/0/0", i, State, Wr_Ptr, Rd_Valid);
            end
        end
    endtask

    task automatic test_basic_capture;
        logic [127:0] hitv;
        Trig_Addr = 32'h1000;
        Trig_Mask = 32'hFFFF_FFFF;
        hitv = mk(1'b1, 1'b0, 1'b0, 32'h1000, 32'h0, 32'h0);
        tick(1'b1, 128'd0);
        tests++; if (State !== 2'd1) begin fails++; $display("FAIL t2_arm_state got=%0d exp=1", State); end
        for (int i = 0; i < 3; i++) tick(1'b0, mk(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'hA0 + 32'(i)));
        tests++; if (State !== 2'd1 || Wr_Ptr !== 4'd3) begin fails++; $display("FAIL t2_pushes got state=%0d wr=%0d exp 1/3", State, Wr_Ptr); end
        tick(1'b0, hitv);
        tests++; if (State !== 2'd2 || Trig_Ptr !== 4'd3) begin fails++; $display("FAIL t2_trigger got state=%0d trig=%0d exp 2/3", State, Trig_Ptr); end
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, mk(1'b0, 1'b1, 1'b0, 32'h0, 32'hC0 + 32'(i), 32'h0));
            tests++;
            if (State !== ((i == 3) ? 2'd3 : 2'd2) || Done !== (i == 3)) begin
                fails++;
                $display("FAIL t2_post_pop%0d got state=%0d done=%0b", i, State, Done);
            end
        end
        tests++; if (Wr_Ptr !== 4'd8 || Wrapped !== 1'b0 || Trig_Ptr !== 4'd3) begin fails++; $display("FAIL t2_final got wr=%0d wrap=%0b trig=%0d exp 8/0/3", Wr_Ptr, Wrapped, Trig_Ptr); end
        tick(1'b0, mk(1'b1, 1'b0, 1'b1, 32'h1000, 32'h0, 32'hEE));
        tests++; if (Wr_Ptr !== 4'd8 || State !== 2'd3) begin fails++; $display("FAIL t2_done_frozen got wr=%0d state=%0d exp 8/3", Wr_Ptr, State); end
        Rd_En = 1'b1; Rd_Addr = 4'd0;
        tick(1'b0, 128'd0);
        Rd_En = 1'b0;
        tests++; if (Rd_Valid !== 1'b1 || Rd_Data[127:96] !== 32'hA0) begin fails++; $display("FAIL t2_read0 got rv=%0b data=%h exp 1/a0", Rd_Valid, Rd_Data[127:96]); end
        tick(1'b0, 128'd0);
        tests++; if (Rd_Valid !== 1'b0 || Rd_Data[127:96] !== 32'hA0) begin fails++; $display("FAIL t2_read_hold got rv=%0b data=%h exp 0/a0", Rd_Valid, Rd_Data[127:96]); end
        Rd_En = 1'b1; Rd_Addr = 4'd3;
        tick(1'b0, 128'd0);
        Rd_En = 1'b0;
        tests++; if (Rd_Data !== hitv) begin fails++; $display("FAIL t2_read_trig got=%h exp=%h", Rd_Data, hitv); end
        Rd_En = 1'b1; Rd_Addr = 4'd7;
        tick(1'b0, 128'd0);
        Rd_En = 1'b0;
        tests++; if (Rd_Data[95:64] !== 32'hC3) begin fails++; $display("FAIL t2_read_last got=%h exp=c3", Rd_Data[95:64]); end
    endtask

    task automatic test_wrap;
        tick(1'b1, 128'd0);
        for (int i = 0; i < 20; i++) tick(1'b0, mk(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'hB00 + 32'(i)));
        tests++; if (Wr_Ptr !== 4'd4 || Wrapped !== 1'b1 || State !== 2'd1) begin fails++; $display("FAIL t3_wrap got wr=%0d wrap=%0b state=%0d exp 4/1/1", Wr_Ptr, Wrapped, State); end
        // Hit written to address 4 while address 4 is read: old data expected
        Rd_En = 1'b1; Rd_Addr = 4'd4;
        tick(1'b0, mk(1'b1, 1'b0, 1'b0, 32'h1000, 32'h0, 32'h0));
        Rd_En = 1'b0;
        tests++; if (Trig_Ptr !== 4'd4 || State !== 2'd2) begin fails++; $display("FAIL t3_trig got trig=%0d state=%0d exp 4/2", Trig_Ptr, State); end
        tests++; if (Rd_Valid !== 1'b1 || Rd_Data[127:96] !== 32'hB04) begin fails++; $display("FAIL t3_read_first got rv=%0b data=%h exp 1/b04", Rd_Valid, Rd_Data[127:96]); end
        for (int i = 0; i < 4; i++) tick(1'b0, mk(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'hD0));
        tests++; if (Wr_Ptr !== 4'd9 || State !== 2'd3 || Wrapped !== 1'b1) begin fails++; $display("FAIL t3_done got wr=%0d state=%0d wrap=%0b exp 9/3/1", Wr_Ptr, State, Wrapped); end
        Rd_En = 1'b1; Rd_Addr = 4'd4;
        tick(1'b0, 128'd0);
        Rd_En = 1'b0;
        tests++; if (Rd_Data[32] !== 1'b1 || Rd_Data[31:0] !== 32'h1000) begin fails++; $display("FAIL t3_read_trig got ack=%0b addr=%h exp 1/1000", Rd_Data[32], Rd_Data[31:0]); end
    endtask

    task automatic test_mask;
        Trig_Mask = 32'hFFFF_F000;
        Trig_Addr = 32'h2000;
        tick(1'b1, 128'd0);
        tick(1'b0, mk(1'b1, 1'b0, 1'b0, 32'h3000, 32'h0, 32'h0));
        tests++; if (State !== 2'd1 || Wr_Ptr !== 4'd1) begin fails++; $display("FAIL t4_nomatch got state=%0d wr=%0d exp 1/1", State, Wr_Ptr); end
        tick(1'b0, mk(1'b1, 1'b0, 1'b0, 32'h2ABC, 32'h0, 32'h0));
        tests++; if (State !== 2'd2 || Trig_Ptr !== 4'd1) begin fails++; $display("FAIL t4_match got state=%0d trig=%0d exp 2/1", State, Trig_Ptr); end
        tick(1'b0, mk(1'b1, 1'b0, 1'b0, 32'h2000, 32'h0, 32'h0));
        tests++; if (State !== 2'd2 || Trig_Ptr !== 4'd1 || Wr_Ptr !== 4'd3) begin fails++; $display("FAIL t4_rehit_ignored got state=%0d trig=%0d wr=%0d exp 2/1/3", State, Trig_Ptr, Wr_Ptr); end
    endtask

    task automatic test_arm_hit;
        Trig_Addr = 32'h1000;
        Trig_Mask = 32'hFFFF_FFFF;
        tick(1'b1, mk(1'b1, 1'b0, 1'b0, 32'h1000, 32'h0, 32'h0));
        tests++; if (State !== 2'd1 || Wr_Ptr !== 4'd0 || Trig_Ptr !== 4'd0) begin fails++; $display("FAIL t5_arm_priority got state=%0d wr=%0d trig=%0d exp 1/0/0", State, Wr_Ptr, Trig_Ptr); end
        tick(1'b0, mk(1'b1, 1'b0, 1'b0, 32'h1000, 32'h0, 32'h0));
        tests++; if (State !== 2'd2 || Trig_Ptr !== 4'd0 || Wr_Ptr !== 4'd1) begin fails++; $display("FAIL t5_hit_after got state=%0d trig=%0d wr=%0d exp 2/0/1", State, Trig_Ptr, Wr_Ptr); end
    endtask

    task automatic test_async_reset;
        tick(1'b1, 128'd0);
        tick(1'b0, mk(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h11));
        tick(1'b0, mk(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h22));
        tick(1'b0, mk(1'b1, 1'b0, 1'b0, 32'h1000, 32'h0, 32'h0));
        Rd_En = 1'b1; Rd_Addr = 4'd2;
        tick(1'b0, mk(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0));
        Rd_En = 1'b0;
        tests++; if (State !== 2'd2 || Trig_Ptr !== 4'd2 || Rd_Valid !== 1'b1) begin fails++; $display("FAIL t6_setup got state=%0d trig=%0d rv=%0b exp 2/2/1", State, Trig_Ptr, Rd_Valid); end
        #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if (State !== 2'd0 || Done !== 1'b0 || Wr_Ptr !== 4'd0 || Trig_Ptr !== 4'd0 ||
            Wrapped !== 1'b0 || Rd_Data !== 128'd0 || Rd_Valid !== 1'b0) begin
            fails++;
            $display("FAIL t6_async_reset got state=%0d wr=%0d trig=%0d wrap=%0b rv=%0b data=%h exp all zero",
                     State, Wr_Ptr, Trig_Ptr, Wrapped, Rd_Valid, Rd_Data);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'b0, mk(1'b1, 1'b1, 1'b1, 32'h1000, 32'h0, 32'h0));
        tests++; if (State !== 2'd0 || Wr_Ptr !== 4'd0) begin fails++; $display("FAIL t6_no_write got state=%0d wr=%0d exp 0/0", State, Wr_Ptr); end
    endtask

    initial begin
        rst_n     = 1'b0;
        PIM_dbg   = 128'd0;
        Arm       = 1'b0;
        Trig_Addr = 32'h0;
        Trig_Mask = 32'h0;
        Rd_En     = 1'b0;
        Rd_Addr   = 4'd0;
        test_reset;
        test_basic_capture;
        test_wrap;
        test_mask;
        test_arm_hit;
        test_async_reset;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
